// File: rtl/mul4_product_accumulator.sv
// mul4_product_accumulator
// Sums a fixed group of COUNT unsigned 8-bit products into an ACC_W-bit
// result and presents each finished sum, with a sticky overflow flag, on a
// valid/ready output port. Define PROD_ACC_SAT_EN to make the accumulator
// clamp at all-ones on overflow; by default it wraps modulo 2^ACC_W.
module mul4_product_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Index of the final product in a group; COUNT is at most 255.
  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t           state;
  state_t           next_state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST_CNT);

  // Next accumulator value and overflow flag for the product on the input.
  always_comb begin
    sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, in_prod};
    carry    = sum_ext[ACC_W];
`ifdef PROD_ACC_SAT_EN
    acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    ovf_next = ovf | carry;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= next_state;
  end

  // Next-state logic: clr aborts to ACCUM, the last product enters HOLD,
  // and the output handshake releases HOLD.
  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last) next_state = HOLD;
        HOLD:    if (out_ready)      next_state = ACCUM;
        default:                     next_state = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // Accumulator, product counter, overflow flag and the registered result;
  // the running sum restarts on the same edge that captures a finished group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_sum <= acc_next;
        out_ovf <= ovf_next;
        acc     <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + 8'd1;
        ovf <= ovf_next;
      end
    end
  end

endmodule
